traffic_light_ctrl: RTL and testbench

Phase sequencer that sits directly upstream and downstream of the long/short interval counter. It issues one-cycle trigger pulses on trL/trS and consumes the counter's tL/tS timeout pulses. It drives a four-phase signal head: RED, RED_YELLOW, GREEN, YELLOW.
A per-phase watchdog catches a missing or wrong-type timeout and latches a flashing-yellow fault mode.

---
 rtl/traffic_light_ctrl.sv | 150 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: four-phase signal-head sequencer driving a long/short interval counter,
// with per-phase watchdog and flashing-yellow fault mode. Define PED_REQ_EN for pedestrian RED extension.
`default_nettype none

module traffic_light_ctrl #(
  parameter int WD_LIMIT     = 64,
  parameter int FLASH_PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tL,
  input  logic tS,
  input  logic ped_req,
  output logic trL,
  output logic trS,
  output logic red,
  output logic yellow,
  output logic green,
  output logic fault,
  output logic ped_ack
);

  typedef enum logic [2:0] {
    START      = 3'd0,
    RED        = 3'd1,
    RED_YELLOW = 3'd2,
    GREEN      = 3'd3,
    YELLOW     = 3'd4,
    FAULT      = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [31:0] wd, wd_nx;
  logic [31:0] flash, flash_nx;
  logic        ped_pending, ped_pending_nx;
  logic        red_nx, yellow_nx, green_nx, trl_nx, trs_nx, fault_nx, ped_ack_nx;
  logic        is_long, waiting, exp_pulse, wrong_pulse, enter, ped_repeat;

  function automatic state_t next_phase(input state_t s);
    case (s)
      RED:        next_phase = RED_YELLOW;
      RED_YELLOW: next_phase = GREEN;
      GREEN:      next_phase = YELLOW;
      default:    next_phase = RED;
    endcase
  endfunction

  always_comb begin
    state_nx    = state;
    wd_nx       = wd + 32'd1;
    flash_nx    = flash;
    enter       = 1'b0;
    ped_ack_nx  = 1'b0;
    yellow_nx   = 1'b0;
    is_long     = (state == RED) || (state == GREEN);
    // The trigger cycle itself is never a waiting cycle: timeouts seen there are stale.
    waiting     = (state inside {RED, RED_YELLOW, GREEN, YELLOW}) && !(trL || trS);
    exp_pulse   = is_long ? tL : tS;
    wrong_pulse = is_long ? tS : tL;
`ifdef PED_REQ_EN
    ped_pending_nx = (state != FAULT) ? (ped_pending | ped_req) : ped_pending;
`else
    ped_pending_nx = 1'b0;
`endif
    ped_repeat  = (state == RED) && ped_pending;

    case (state)
      START: begin
        state_nx = RED;
        enter    = 1'b1;
      end
      RED, RED_YELLOW, GREEN, YELLOW: begin
        if (waiting) begin
          if (wrong_pulse) begin
            state_nx = FAULT;
          end else if (exp_pulse) begin
            enter = 1'b1;
            if (ped_repeat) begin
              ped_ack_nx     = 1'b1;
              ped_pending_nx = ped_req;
            end else begin
              state_nx = next_phase(state);
            end
          end else if (wd == 32'(WD_LIMIT - 1)) begin
            state_nx = FAULT;
          end
        end
      end
      FAULT: begin
        if (flash == 32'(FLASH_PERIOD - 1)) begin
          flash_nx  = 32'd0;
          yellow_nx = ~yellow;
        end else begin
          flash_nx  = flash + 32'd1;
          yellow_nx = yellow;
        end
      end
      default: state_nx = START;
    endcase

    if (enter) wd_nx = 32'd0;

    if (state_nx == FAULT) begin
      if (state != FAULT) begin
        yellow_nx = 1'b1;
        flash_nx  = 32'd0;
      end
      wd_nx = 32'd0;
    end else begin
      yellow_nx = (state_nx == RED_YELLOW) || (state_nx == YELLOW);
    end

    red_nx   = (state_nx == START) || (state_nx == RED) || (state_nx == RED_YELLOW);
    green_nx = (state_nx == GREEN);
    trl_nx   = enter && ((state_nx == RED) || (state_nx == GREEN));
    trs_nx   = enter && ((state_nx == RED_YELLOW) || (state_nx == YELLOW));
    fault_nx = (state_nx == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= START;
      wd          <= 32'd0;
      flash       <= 32'd0;
      ped_pending <= 1'b0;
      red         <= 1'b1;
      yellow      <= 1'b0;
      green       <= 1'b0;
      trL         <= 1'b0;
      trS         <= 1'b0;
      fault       <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      state       <= state_nx;
      wd          <= wd_nx;
      flash       <= flash_nx;
      ped_pending <= ped_pending_nx;
      red         <= red_nx;
      yellow      <= yellow_nx;
      green       <= green_nx;
      trL         <= trl_nx;
      trS         <= trs_nx;
      fault       <= fault_nx;
      ped_ack     <= ped_ack_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: closed-loop interval counter, phase-level reference model, random and directed stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_traffic_light_ctrl;
  localparam int WD = 16;
  localparam int FP = 8;
  localparam int LV = 4;
  localparam int SV = 2;
`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, tL, tS, ped_req;
  logic trL, trS, red, yellow, green, fault, ped_ack;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.WD_LIMIT(WD), .FLASH_PERIOD(FP)) dut (
    .clk(clk), .reset(reset), .tL(tL), .tS(tS), .ped_req(ped_req),
    .trL(trL), .trS(trS), .red(red), .yellow(yellow), .green(green),
    .fault(fault), .ped_ack(ped_ack)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model: phase -1 = START, 0..3 = RED, RED_YELLOW, GREEN, YELLOW (even = long), 4 = FAULT
  int m_phase = -1;
  int m_age   = 0;
  int m_fage  = 0;
  bit m_pend  = 1'b0;
  bit m_ack   = 1'b0;

  bit cnt_en    = 1'b1;
  int fire_at   = -1;
  bit fire_long = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // {red, yellow, green, trL, trS, fault, ped_ack}
  function automatic logic [6:0] m_out();
    logic [6:0] o;
    o = '0;
    if (m_phase < 0) begin
      o[6] = 1'b1;
    end else if (m_phase == 4) begin
      o[5] = ((m_fage / FP) % 2) == 0;
      o[1] = 1'b1;
    end else begin
      o[6] = (m_phase <= 1);
      o[5] = (m_phase % 2) == 1;
      o[4] = (m_phase == 2);
      o[3] = (m_age == 0) && (m_phase % 2 == 0);
      o[2] = (m_age == 0) && (m_phase % 2 == 1);
      o[0] = m_ack;
    end
    return o;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit s, input bit p);
    bit pend_next, long_ph, expd, wrong;
    if (r) begin
      m_phase = -1; m_age = 0; m_pend = 1'b0; m_ack = 1'b0;
      return;
    end
    m_ack = 1'b0;
    if (m_phase == 4) begin
      m_fage++;
      return;
    end
    pend_next = PED ? (m_pend | p) : 1'b0;
    if (m_phase < 0) begin
      m_phase = 0; m_age = 0; m_pend = pend_next;
      return;
    end
    long_ph = (m_phase % 2) == 0;
    expd    = long_ph ? l : s;
    wrong   = long_ph ? s : l;
    if (m_age > 0 && wrong) begin
      m_phase = 4; m_fage = 0;
    end else if (m_age > 0 && expd) begin
      if (PED && m_phase == 0 && m_pend) begin
        m_age = 0; m_ack = 1'b1; pend_next = p;
      end else begin
        m_phase = (m_phase + 1) % 4; m_age = 0;
      end
    end else if (m_age == WD - 1) begin
      m_phase = 4; m_fage = 0;
    end else begin
      m_age++;
    end
    m_pend = pend_next;
  endtask

  task automatic tick(input bit r, input bit xl, input bit xs, input bit pr);
    bit cl, cs;
    cl = cnt_en && (fire_at == cyc) && fire_long;
    cs = cnt_en && (fire_at == cyc) && !fire_long;
    if (trL === 1'b1) begin fire_at = cyc + LV + 1; fire_long = 1'b1; end
    else if (trS === 1'b1) begin fire_at = cyc + SV + 1; fire_long = 1'b0; end
    reset = r; tL = cl | xl; tS = cs | xs; ped_req = pr;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, tL, tS, pr);
    check("outputs", {25'd0, red, yellow, green, trL, trS, fault, ped_ack}, {25'd0, m_out()});
  endtask

  initial begin
    #400us;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int last, ntrig, t0, t1, acks;
    reset = 1'b1; tL = 1'b0; tS = 1'b0; ped_req = 1'b0;

    // Reset state and three full sequences with a 4/2 counter
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("reset_state", {25'd0, red, yellow, green, trL, trS, fault, ped_ack}, 32'h40);
    last = -1; ntrig = 0;
    for (int i = 0; i < 62; i++) begin
      tick(0, 0, 0, 0);
      if (trL || trS) begin
        if (last >= 0)
          check("phase_len", cyc - last, ((ntrig - 1) % 2 == 0) ? LV + 2 : SV + 2);
        last = cyc; ntrig++;
      end
    end
    check("trigger_count", ntrig, 13);

    // Reset pulse in the middle of GREEN
    for (int i = 0; i < 40 && !(m_phase == 2 && m_age == 0); i++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("mid_reset", {29'd0, red, green, trL}, 32'h4);
    tick(0, 0, 0, 0);
    check("red_reentry", {30'd0, red, trL}, 32'h3);
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0);

    // No counter attached: watchdog fault, then flashing for 100 cycles
    cnt_en = 1'b0;
    tick(1, 0, 0, 0);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 10 && t0 < 0; i++) begin tick(0, 0, 0, 0); if (trL) t0 = cyc; end
    for (int i = 0; i < 40 && t1 < 0; i++) begin tick(0, 0, 0, 0); if (fault) t1 = cyc; end
    check("wd_fault_delay", t1 - t0, WD);
    for (int i = 0; i < 100; i++) tick(0, 0, 0, 0);
    check("fault_sticky", {31'd0, fault}, 32'h1);
    cnt_en = 1'b1; fire_at = -1;

    // Wrong-type tS while waiting in GREEN (one in its trigger cycle is ignored)
    tick(1, 0, 0, 0);
    for (int i = 0; i < 60 && m_phase != 4; i++)
      tick(0, 0, (m_phase == 2) && (m_age == 0 || m_age == 2), 0);
    check("ts_in_green_fault", {30'd0, fault, green}, 32'h2);

    // Pedestrian request during GREEN
    tick(1, 0, 0, 0);
    for (int i = 0; i < 40 && !(m_phase == 2 && m_age == 1); i++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    t0 = -1; t1 = -1; acks = 0;
    for (int i = 0; i < 60 && t1 < 0; i++) begin
      tick(0, 0, 0, 0);
      if (ped_ack) acks++;
      if (trL && red && !yellow && t0 < 0) t0 = cyc;
      if (trS && red && yellow && t0 >= 0) t1 = cyc;
    end
    check("ped_red_len", t1 - t0, PED ? 2 * (LV + 2) : LV + 2);
    check("ped_ack_count", acks, PED ? 1 : 0);

    // Randomized closed-loop run with occasional stray pulses and resets
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 14) == 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
